// File: rtl/max_finder_stream.sv
// max_finder_stream
// Streaming argmax over a set of N signed elements that arrive z per beat.
// After the last beat of a set the largest element and its index are held
// on out_max/out_pos until the consumer takes them. Ties go to the lower index.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   in_data holds a beat
//   in_ready   a beat is accepted this cycle (high while accumulating)
//   in_data    z lanes of signed elements; lane j is element beat*z+j
//   out_valid  result is held and valid
//   out_ready  consumer takes the result
//   out_max    largest element of the set
//   out_pos    index 0..N-1 of out_max
//
// State | meaning
// ------+---------------------------------------------------------------
// ACCUM | taking beats, folding each into the running max (in_ready=1)
// HOLD  | result registered, waiting for out_ready (out_valid=1)
module max_finder_stream #(
  parameter int width    = 13,
  parameter int N        = 37,
  parameter int z        = 4,
  parameter int poswidth = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [width-1:0] in_data [z-1:0],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [width-1:0] out_max,
  output logic [poswidth-1:0]     out_pos
);

  localparam int BEATS = (N + z - 1) / z;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t state, state_nx;

  logic [CW-1:0]           beat_cnt;
  logic signed [width-1:0] run_max;
  logic [poswidth-1:0]     run_pos;

  logic                    accept;
  logic                    last_beat;
  int                      base;
  logic signed [width-1:0] beat_max;
  logic [poswidth-1:0]     beat_pos;
  logic signed [width-1:0] new_max;
  logic [poswidth-1:0]     new_pos;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == CW'(BEATS - 1));

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM: if (accept && last_beat) state_nx = HOLD;
      HOLD:  if (out_ready)           state_nx = ACCUM;
      default:                        state_nx = ACCUM;
    endcase
  end

  // Lane 0 of any beat is always a real element, so it seeds the in-beat
  // chain; higher lanes must be strictly greater to win, which keeps the
  // lower index on ties. Lanes past N-1 (tail of the last beat) never compete.
  always_comb begin
    base     = int'(beat_cnt) * z;
    beat_max = in_data[0];
    beat_pos = poswidth'(base);
    for (int j = 1; j < z; j++) begin
      if ((base + j) < N && in_data[j] > beat_max) begin
        beat_max = in_data[j];
        beat_pos = poswidth'(base + j);
      end
    end
    new_max = beat_max;
    new_pos = beat_pos;
    // Beat 0 starts a fresh set; later beats only replace on strictly greater,
    // so an earlier-beat winner survives a tie.
    if (beat_cnt != '0 && !(beat_max > run_max)) begin
      new_max = run_max;
      new_pos = run_pos;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACCUM;
      beat_cnt <= '0;
      run_max  <= '0;
      run_pos  <= '0;
      out_max  <= '0;
      out_pos  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        run_max <= new_max;
        run_pos <= new_pos;
        if (last_beat) begin
          beat_cnt <= '0;
          out_max  <= new_max;
          out_pos  <= new_pos;
        end else begin
          beat_cnt <= beat_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_max_finder_stream.sv
// Directed and randomised bench for max_finder_stream with default parameters.
module tb_max_finder_stream;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [12:0] in_data [3:0];
  logic               out_valid;
  logic               out_ready;
  logic signed [12:0] out_max;
  logic [5:0]         out_pos;

  int checks = 0;
  int errors = 0;

  logic signed [12:0] elems [37];
  logic signed [12:0] pad;

  max_finder_stream dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_pos   (out_pos)
  );

  always #5 clk = ~clk;

  // Lowest-index-wins reference over the current elems[].
  task automatic ref_argmax(output logic signed [12:0] m, output int p);
    m = elems[0];
    p = 0;
    for (int i = 1; i < 37; i++) begin
      if (elems[i] > m) begin
        m = elems[i];
        p = i;
      end
    end
  endtask

  // Drive beat b after 'gap' idle cycles; returns on the negedge after acceptance.
  task automatic send_beat(input int b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: beat %0d in_ready=%0b required 1", b, in_ready);
    end
    for (int j = 0; j < 4; j++)
      in_data[j] = (b * 4 + j < 37) ? elems[b * 4 + j] : pad;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_set(input int gap_max);
    for (int b = 0; b < 10; b++)
      send_beat(b, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pad       = '0;
    for (int j = 0; j < 4; j++) in_data[j] = '0;
    do_reset();
    checks++; if (in_ready !== 1'b1)
      begin errors++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0)
      begin errors++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_max !== 13'sd0)
      begin errors++; $display("FAIL rst_out_max: got %0d expected 0", out_max); end
    checks++; if (out_pos !== 6'd0)
      begin errors++; $display("FAIL rst_out_pos: got %0d expected 0", out_pos); end
  endtask

  task automatic test_ascending();
    for (int i = 0; i < 37; i++) elems[i] = 13'(i);
    pad       = '0;
    out_ready = 1'b1;
    for (int b = 0; b < 9; b++) send_beat(b, 0);
    checks++; if (out_valid !== 1'b0)
      begin errors++; $display("FAIL asc_early_valid: got %0b expected 0", out_valid); end
    send_beat(9, 0);
    checks++; if (out_valid !== 1'b1)
      begin errors++; $display("FAIL asc_latency: out_valid got %0b expected 1", out_valid); end
    checks++; if (out_max !== 13'sd36)
      begin errors++; $display("FAIL asc_max: got %0d expected 36", out_max); end
    checks++; if (out_pos !== 6'd36)
      begin errors++; $display("FAIL asc_pos: got %0d expected 36", out_pos); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL asc_release: out_valid=%0b in_ready=%0b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_ties();
    for (int i = 0; i < 37; i++) elems[i] = -13'sd5;
    elems[6]  = 13'sd100;
    elems[21] = 13'sd100;
    pad       = '0;
    out_ready = 1'b1;
    send_set(0);
    checks++; if (out_valid !== 1'b1)
      begin errors++; $display("FAIL ties_valid: got %0b expected 1", out_valid); end
    checks++; if (out_max !== 13'sd100)
      begin errors++; $display("FAIL ties_max: got %0d expected 100", out_max); end
    checks++; if (out_pos !== 6'd6)
      begin errors++; $display("FAIL ties_pos: got %0d expected 6", out_pos); end
    @(negedge clk);
  endtask

  task automatic test_lane_mask();
    for (int i = 0; i < 37; i++) elems[i] = -13'sd4096;
    pad       = 13'sd4095;
    out_ready = 1'b1;
    send_set(0);
    checks++; if (out_max !== -13'sd4096)
      begin errors++; $display("FAIL mask_max: got %0d expected -4096", out_max); end
    checks++; if (out_pos !== 6'd0)
      begin errors++; $display("FAIL mask_pos: got %0d expected 0", out_pos); end
    @(negedge clk);
  endtask

  // Set value (7*i mod 50) - 20: max 29 first reached at i=7.
  task automatic test_backpressure();
    int bad;
    for (int i = 0; i < 37; i++) elems[i] = 13'((i * 7) % 50 - 20);
    pad       = '0;
    out_ready = 1'b0;
    send_set(0);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      for (int j = 0; j < 4; j++) in_data[j] = 13'sd4000;
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_max !== 13'sd29 || out_pos !== 6'd7) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: in_ready=%0b out_valid=%0b max=%0d pos=%0d expected 0/1/29/7",
                 c, in_ready, out_valid, out_max, out_pos);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_release: out_valid=%0b in_ready=%0b expected 0/1", out_valid, in_ready); end
    for (int i = 0; i < 37; i++) elems[i] = 13'(i);
    send_set(0);
    checks++; if (out_valid !== 1'b1 || out_max !== 13'sd36 || out_pos !== 6'd36)
      begin errors++; $display("FAIL bp_second: valid=%0b max=%0d pos=%0d expected 1/36/36", out_valid, out_max, out_pos); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic signed [12:0] em;
    int ep;
    for (int i = 0; i < 37; i++) elems[i] = -13'sd100;
    elems[2]  = 13'sd4095;
    pad       = '0;
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) send_beat(b, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 37; i++) elems[i] = 13'($random % 4096);
    elems[2] = -13'sd4095;
    ref_argmax(em, ep);
    for (int b = 0; b < 9; b++) send_beat(b, 0);
    checks++; if (out_valid !== 1'b0)
      begin errors++; $display("FAIL rmid_early_valid: got %0b expected 0", out_valid); end
    send_beat(9, 0);
    checks++; if (out_valid !== 1'b1 || out_max !== em || out_pos !== 6'(ep))
      begin errors++; $display("FAIL rmid_result: valid=%0b max=%0d pos=%0d expected 1/%0d/%0d", out_valid, out_max, out_pos, em, ep); end
    @(negedge clk);
  endtask

  task automatic test_reset_hold();
    for (int i = 0; i < 37; i++) elems[i] = 13'(50 - i);
    pad       = '0;
    out_ready = 1'b0;
    send_set(0);
    checks++; if (out_valid !== 1'b1 || out_max !== 13'sd50)
      begin errors++; $display("FAIL rhold_pre: valid=%0b max=%0d expected 1/50", out_valid, out_max); end
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_max !== 13'sd0 || out_pos !== 6'd0) begin
      errors++;
      $display("FAIL rhold_cleared: valid=%0b in_ready=%0b max=%0d pos=%0d expected 0/1/0/0",
               out_valid, in_ready, out_max, out_pos);
    end
  endtask

  task automatic test_bubbles();
    logic signed [12:0] em;
    int ep;
    out_ready = 1'b1;
    for (int s = 0; s < 100; s++) begin
      for (int i = 0; i < 37; i++) elems[i] = 13'($urandom_range(0, 8191));
      if (s % 4 == 0) elems[$urandom_range(0, 36)] = elems[$urandom_range(0, 36)];
      pad = 13'($urandom_range(0, 8191));
      ref_argmax(em, ep);
      send_set(3);
      checks++;
      if (out_valid !== 1'b1 || out_max !== em || out_pos !== 6'(ep)) begin
        errors++;
        $display("FAIL bubbles set %0d: valid=%0b max=%0d pos=%0d expected 1/%0d/%0d",
                 s, out_valid, out_max, out_pos, em, ep);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) in_data[j] = '0;
    @(negedge clk);
    test_reset();
    test_ascending();
    test_ties();
    test_lane_mask();
    test_backpressure();
    test_reset_mid();
    test_reset_hold();
    test_bubbles();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_finder_stream.md
MAX_FINDER_STREAM -- requirements
Module: max_finder_stream

Interface
REQ-001 SHALL have parameter width, default 13, signed element width in bits.
REQ-002 SHALL have parameter N, default 37, number of elements per set.
REQ-003 SHALL have parameter z, default 4, elements delivered per input beat.
REQ-004 SHALL have parameter poswidth, default $clog2(N), width of the position output.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge triggered.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1, meaning in_data holds a beat.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-009 SHALL have port in_data, input, z x width signed (unpacked [z-1:0]); lane j holds element beat*z+j.
REQ-010 SHALL have port out_valid, output, 1, meaning the result is held and valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-012 SHALL have port out_max, output, width signed, the largest element of the set.
REQ-013 SHALL have port out_pos, output, poswidth, the index 0..N-1 of out_max.

Function
REQ-014 SHALL define BEATS = ceil(N/z), which is 10 for the defaults.
REQ-015 SHALL accept a beat only when in_valid and in_ready are both high on a rising edge.
REQ-016 SHALL implement two states:
- ACCUM: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
REQ-017 SHALL keep a beat counter beat_cnt, 0..BEATS-1, incremented on each accepted beat.
REQ-018 SHALL treat lanes whose index beat*z+j >= N as absent: they are never compared. For the defaults, lanes 1..3 of beat 9 are absent.
REQ-019 SHALL on beat 0 load the running max and position from that beat's lanes only, ignoring any prior contents.
REQ-020 SHALL on each later beat compare the lanes against the running max using signed comparison.
REQ-021 SHALL replace the running max only when a candidate is strictly greater.
- Ties keep the lower index.
- Within a beat, a lower lane wins a tie against a higher lane.
REQ-022 SHALL on the accepted beat BEATS-1:
- register the final max and position into out_max and out_pos;
- reset beat_cnt to 0;
- move to HOLD.
out_valid SHALL rise on the next cycle, so latency is 1 cycle after the last beat.
REQ-023 SHALL in HOLD keep out_max and out_pos stable until out_valid and out_ready are both high.
REQ-024 SHALL on the out_valid & out_ready handshake return to ACCUM, with in_ready=1 on the following cycle. There is no same-cycle input acceptance in HOLD.
REQ-025 SHALL ignore in_valid while in HOLD. No beat is consumed and no state changes.
REQ-026 SHALL leave counters and state unchanged when in_valid is low in ACCUM. Gaps between beats are allowed.
REQ-027 SHALL compute position as beat_cnt*z+j in poswidth bits, with no overflow for any legal N and z.
REQ-028 SHALL keep the comparison logic per beat purely combinational, at z-1 comparator depth plus one against the running max, registered once per beat.

Reset
REQ-029 SHALL while reset is high on a clock edge set:
- state ACCUM, beat_cnt 0;
- running max and position to 0;
- out_max 0, out_pos 0, out_valid 0;
- in_ready 1 from the first cycle after reset deasserts.
REQ-030 SHALL on reset during ACCUM discard the partial set. The next accepted beat is beat 0.
REQ-031 SHALL on reset during HOLD drop the held result without any handshake.
REQ-032 SHALL give reset priority over a simultaneous in or out handshake.

Verification
REQ-033 Ascending set: elements i = 0..36 with value i, 10 beats back-to-back, out_ready=1 -> out_valid one cycle after beat 9, out_max=36, out_pos=36.
REQ-034 Ties and negatives: all elements -5 except element 6 = 100 and element 21 = 100 -> out_max=100, out_pos=6.
REQ-035 Lane masking: all valid elements -4096; absent lanes 1..3 of beat 9 driven to 4095 -> out_max=-4096, out_pos=0.
REQ-036 Backpressure: out_ready=0 for 5 cycles after out_valid while in_valid stays high -> in_ready=0 and outputs stable throughout; a second set starts only after the handshake.
REQ-037 Reset mid-set: assert reset after beat 4, then send a full set of $random%4096 values -> result matches a reference argmax of the second set only.
REQ-038 Bubbles: random in_valid gaps of 0-3 cycles over 100 random sets -> every out_max and out_pos pair equals a lowest-index-wins golden model.
